// File: rtl/axi4_burst_mem_slave.sv
// AXI4 full burst memory slave: byte strobes, FIXED/INCR/WRAP, narrow beats, SLVERR.
// Define AXI4_WRAP_BURST_EN to honour WRAP bursts; otherwise they run as INCR with SLVERR.
module axi4_burst_mem_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);

    localparam logic [1:0] B_FIXED = 2'b00;
    localparam logic [1:0] B_INCR  = 2'b01;
    localparam logic [1:0] B_WRAP  = 2'b10;

`ifdef AXI4_WRAP_BURST_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    function automatic logic size_bad(input logic [2:0] size);
        return size > 3'(LANE_W);
    endfunction

    function automatic logic len_legal(input logic [7:0] len);
        return len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
    endfunction

    function automatic logic burst_bad(input logic [1:0] burst, input logic [7:0] len);
        return burst == 2'b11 || (burst == B_WRAP && !(WRAP_EN && len_legal(len)));
    endfunction

    function automatic logic [1:0] eff_mode(input logic [1:0] burst, input logic [7:0] len);
        logic [1:0] m;
        unique case (1'b1)
            burst == B_FIXED: m = B_FIXED;
            burst == B_WRAP && WRAP_EN && len_legal(len): m = B_WRAP;
            default: m = B_INCR;
        endcase
        return m;
    endfunction

    function automatic addr_t next_addr(input addr_t a, input logic [2:0] size,
                                        input logic [7:0] len, input logic [1:0] mode);
        addr_t inc, win, na;
        inc = addr_t'(1) << size;
        win = addr_t'({1'b0, len} + 9'd1) << size;
        na  = a + inc;
        if (mode == B_FIXED)
            na = a;
        else if (mode == B_WRAP)
            na = (a & ~(win - addr_t'(1))) | (na & (win - addr_t'(1)));
        return na;
    endfunction

    function automatic logic in_range(input addr_t a);
        return (a >> LANE_W) < addr_t'(MEM_DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input addr_t a);
        return IDX_W'(a >> LANE_W);
    endfunction

    logic live;

    // Keep the address readies low until the first clock out of reset
    always_ff @(posedge ACLK) live <= ARESETn;

    wstate_t    w_state, w_next;
    addr_t      w_addr;
    logic [7:0] w_len, w_cnt;
    logic [2:0] w_size;
    logic [1:0] w_mode;
    logic       w_err, w_skip;
    logic       aw_fire, w_fire, w_last, w_beat_err, w_store;

    assign aw_fire    = AWVALID && AWREADY;
    assign w_fire     = WVALID && WREADY;
    assign w_last     = w_cnt == w_len;
    assign w_beat_err = !in_range(w_addr) || (WLAST != w_last);
    assign w_store    = w_fire && ARESETn && !w_skip && in_range(w_addr);

    // Write FSM state register
    always_ff @(posedge ACLK) begin
        if (!ARESETn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    // Write FSM next state and channel handshakes
    always_comb begin
        w_next  = w_state;
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        BRESP   = 2'b00;
        case (w_state)
            W_IDLE: begin
                AWREADY = live;
                if (live && AWVALID) w_next = W_DATA;
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (WVALID && w_last) w_next = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                BRESP  = w_err ? 2'b10 : 2'b00;
                if (BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write burst tracking: address, beat count, sticky error
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            w_addr <= '0;
            w_len  <= '0;
            w_cnt  <= '0;
            w_size <= '0;
            w_mode <= B_INCR;
            w_err  <= 1'b0;
            w_skip <= 1'b0;
        end else if (aw_fire) begin
            w_addr <= AWADDR;
            w_len  <= AWLEN;
            w_cnt  <= '0;
            w_size <= AWSIZE;
            w_mode <= eff_mode(AWBURST, AWLEN);
            w_err  <= size_bad(AWSIZE) || burst_bad(AWBURST, AWLEN);
            w_skip <= size_bad(AWSIZE);
        end else if (w_fire) begin
            w_addr <= next_addr(w_addr, w_size, w_len, w_mode);
            w_cnt  <= w_cnt + 8'd1;
            if (w_beat_err) w_err <= 1'b1;
        end
    end

    // Byte-lane write of accepted beats; contents survive reset
    always_ff @(posedge ACLK) begin
        if (w_store) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WSTRB[b]) mem[word_idx(w_addr)][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    rstate_t               r_state, r_next;
    addr_t                 r_addr, r_na, f_addr;
    logic [7:0]            r_len, r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_mode;
    logic                  r_err, r_skip, f_skip, f_err;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  ar_fire, r_fire, r_last, r_load;

    assign ar_fire = ARVALID && ARREADY;
    assign r_fire  = RVALID && RREADY;
    assign r_last  = r_cnt == r_len;
    assign r_na    = next_addr(r_addr, r_size, r_len, r_mode);
    assign r_load  = ar_fire || (r_fire && !r_last);
    assign f_addr  = ar_fire ? ARADDR : r_na;
    assign f_skip  = ar_fire ? size_bad(ARSIZE) : r_skip;
    assign f_err   = ar_fire ? (size_bad(ARSIZE) || burst_bad(ARBURST, ARLEN)) : r_err;
    assign RDATA   = r_data;
    assign RRESP   = r_resp;

    // Read FSM state register
    always_ff @(posedge ACLK) begin
        if (!ARESETn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    // Read FSM next state and channel handshakes
    always_comb begin
        r_next  = r_state;
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        RLAST   = 1'b0;
        case (r_state)
            R_IDLE: begin
                ARREADY = live;
                if (live && ARVALID) r_next = R_DATA;
            end
            R_DATA: begin
                RVALID = 1'b1;
                RLAST  = r_last;
                if (RREADY && r_last) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read burst tracking and registered beat fetch (pre-write data on collision)
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_addr <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
            r_size <= '0;
            r_mode <= B_INCR;
            r_err  <= 1'b0;
            r_skip <= 1'b0;
            r_data <= '0;
            r_resp <= 2'b00;
        end else begin
            if (ar_fire) begin
                r_addr <= ARADDR;
                r_len  <= ARLEN;
                r_cnt  <= '0;
                r_size <= ARSIZE;
                r_mode <= eff_mode(ARBURST, ARLEN);
                r_err  <= f_err;
                r_skip <= f_skip;
            end else if (r_fire && !r_last) begin
                r_addr <= r_na;
                r_cnt  <= r_cnt + 8'd1;
            end
            if (r_load) begin
                r_data <= (!f_skip && in_range(f_addr)) ? mem[word_idx(f_addr)] : '0;
                r_resp <= (f_err || !in_range(f_addr)) ? 2'b10 : 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Directed self-checking bench for axi4_burst_mem_slave (32-bit, 1024 words).
// WRAP expectations follow whether AXI4_WRAP_BURST_EN is defined.
module tb_axi4_burst_mem_slave;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    int checks = 0;
    int errors = 0;
    logic [31:0] wd [16];
    logic [31:0] rx [16];
    logic [1:0]  rr [16];

    axi4_burst_mem_slave #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MEM_DEPTH(1024)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string pfx);
        check({pfx, "_awready"}, 32'(AWREADY), 0);
        check({pfx, "_wready"},  32'(WREADY),  0);
        check({pfx, "_bvalid"},  32'(BVALID),  0);
        check({pfx, "_bresp"},   32'(BRESP),   0);
        check({pfx, "_arready"}, 32'(ARREADY), 0);
        check({pfx, "_rvalid"},  32'(RVALID),  0);
        check({pfx, "_rlast"},   32'(RLAST),   0);
        check({pfx, "_rresp"},   32'(RRESP),   0);
        check({pfx, "_rdata"},   RDATA,        0);
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [7:0] l,
                           input logic [2:0] s, input logic [1:0] b);
        int n = 0;
        AWADDR = a; AWLEN = l; AWSIZE = s; AWBURST = b; AWVALID = 1'b1;
        while (AWREADY !== 1'b1 && n < 20) begin tick(); n++; end
        check("aw_handshake", 32'(AWREADY), 1);
        tick();
        AWVALID = 1'b0;
    endtask

    task automatic send_w(input int l, input logic [3:0] strb);
        for (int i = 0; i <= l; i++) begin
            int n = 0;
            WDATA = wd[i]; WSTRB = strb; WLAST = (i == l); WVALID = 1'b1;
            while (WREADY !== 1'b1 && n < 20) begin tick(); n++; end
            check($sformatf("w_handshake%0d", i), 32'(WREADY), 1);
            tick();
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
    endtask

    task automatic get_b(input logic [1:0] exp);
        int n = 0;
        BREADY = 1'b1;
        while (BVALID !== 1'b1 && n < 20) begin tick(); n++; end
        check("bvalid", 32'(BVALID), 1);
        check("bresp", 32'(BRESP), 32'(exp));
        tick();
        BREADY = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                            input logic [1:0] b, input logic [3:0] strb, input logic [1:0] exp);
        send_aw(a, l, s, b);
        send_w(int'(l), strb);
        get_b(exp);
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [7:0] l,
                           input logic [2:0] s, input logic [1:0] b);
        int n = 0;
        ARADDR = a; ARLEN = l; ARSIZE = s; ARBURST = b; ARVALID = 1'b1;
        while (ARREADY !== 1'b1 && n < 20) begin tick(); n++; end
        check("ar_handshake", 32'(ARREADY), 1);
        tick();
        ARVALID = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] l,
                           input logic [2:0] s, input logic [1:0] b);
        send_ar(a, l, s, b);
        for (int i = 0; i <= int'(l); i++) begin
            int n = 0;
            RREADY = 1'b1;
            while (RVALID !== 1'b1 && n < 20) begin tick(); n++; end
            check($sformatf("rvalid%0d", i), 32'(RVALID), 1);
            check($sformatf("rdata%0d", i), RDATA, rx[i]);
            check($sformatf("rresp%0d", i), 32'(RRESP), 32'(rr[i]));
            check($sformatf("rlast%0d", i), 32'(RLAST), 32'(i == int'(l)));
            tick();
        end
        RREADY = 1'b0;
    endtask

    initial begin
        int beats;
        ARESETn = 1'b0;
        AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
        RREADY = 1'b0;
        tick();
        tick();
        check_quiet("reset");
        ARESETn = 1'b1;
        tick();

        // INCR write and read back
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        do_write(32'h0, 8'd3, 3'd2, 2'b01, 4'hF, 2'b00);
        for (int i = 0; i < 4; i++) begin rx[i] = wd[i]; rr[i] = 2'b00; end
        do_read(32'h0, 8'd3, 3'd2, 2'b01);

        // WRAP write starting mid-window
        wd[0] = 32'hA1; wd[1] = 32'hA2; wd[2] = 32'hA3; wd[3] = 32'hA4;
`ifdef AXI4_WRAP_BURST_EN
        do_write(32'h8, 8'd3, 3'd2, 2'b10, 4'hF, 2'b00);
        rx[0] = 32'hA3; rx[1] = 32'hA4; rx[2] = 32'hA1; rx[3] = 32'hA2;
        for (int i = 0; i < 4; i++) rr[i] = 2'b00;
        do_read(32'h0, 8'd3, 3'd2, 2'b01);
`else
        do_write(32'h8, 8'd3, 3'd2, 2'b10, 4'hF, 2'b10);
        rx[0] = 32'h11; rx[1] = 32'h22; rx[2] = 32'hA1;
        rx[3] = 32'hA2; rx[4] = 32'hA3; rx[5] = 32'hA4;
        for (int i = 0; i < 6; i++) rr[i] = 2'b00;
        do_read(32'h0, 8'd5, 3'd2, 2'b01);
`endif

        // Partial strobe write
        wd[0] = 32'h12345678;
        do_write(32'h40, 8'd0, 3'd2, 2'b01, 4'hF, 2'b00);
        wd[0] = 32'hAABBCCDD;
        do_write(32'h40, 8'd0, 3'd2, 2'b01, 4'h3, 2'b00);
        rx[0] = 32'h1234CCDD; rr[0] = 2'b00;
        do_read(32'h40, 8'd0, 3'd2, 2'b01);

        // Burst running off the end of memory
        wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h3; wd[3] = 32'h4;
        do_write(32'hFF8, 8'd3, 3'd2, 2'b01, 4'hF, 2'b10);
        rx[0] = 32'h1; rx[1] = 32'h2; rx[2] = 32'h0; rx[3] = 32'h0;
        rr[0] = 2'b00; rr[1] = 2'b00; rr[2] = 2'b10; rr[3] = 2'b10;
        do_read(32'hFF8, 8'd3, 3'd2, 2'b01);

        // Read backpressure with RREADY toggling
        for (int i = 0; i < 8; i++) wd[i] = 32'h100 + 32'(i);
        do_write(32'h100, 8'd7, 3'd2, 2'b01, 4'hF, 2'b00);
        send_ar(32'h100, 8'd7, 3'd2, 2'b01);
        beats = 0;
        for (int c = 0; c < 40 && beats < 8; c++) begin
            RREADY = c[0];
            if (RVALID === 1'b1) begin
                check($sformatf("bp_rdata%0d", beats), RDATA, 32'h100 + 32'(beats));
                if (RREADY) beats++;
            end
            tick();
        end
        RREADY = 1'b0;
        check("bp_beats", 32'(beats), 8);
        check("bp_rvalid_done", 32'(RVALID), 0);

        // Write response stall
        wd[0] = 32'h5A5A;
        send_aw(32'h180, 8'd0, 3'd2, 2'b01);
        send_w(0, 4'hF);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall_bvalid%0d", k), 32'(BVALID), 1);
            check($sformatf("stall_awready%0d", k), 32'(AWREADY), 0);
            tick();
        end
        get_b(2'b00);
        check("awready_after_b", 32'(AWREADY), 1);

        // Reset in the middle of a write burst
        send_aw(32'h200, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 2; i++) begin
            WDATA = 32'hC1 + 32'(i); WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
            check($sformatf("mid_wready%0d", i), 32'(WREADY), 1);
            tick();
        end
        WVALID = 1'b0;
        ARESETn = 1'b0;
        tick();
        check_quiet("midrst");
        ARESETn = 1'b1;
        tick();
        wd[0] = 32'hD1; wd[1] = 32'hD2;
        do_write(32'h300, 8'd1, 3'd2, 2'b01, 4'hF, 2'b00);
        rx[0] = 32'hC1; rx[1] = 32'hC2; rr[0] = 2'b00; rr[1] = 2'b00;
        do_read(32'h200, 8'd1, 3'd2, 2'b01);
        rx[0] = 32'hD1; rx[1] = 32'hD2;
        do_read(32'h300, 8'd1, 3'd2, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_burst_mem_slave.md
Name: axi4_burst_mem_slave

Overview: Parametrised AXI4 full memory slave, the successor to the fixed 32-bit slave. Adds configurable data width and depth, byte strobes, FIXED/INCR/WRAP bursts, narrow transfers (AxSIZE) and SLVERR signalling. Sits behind the interconnect as a simulation/FPGA scratch memory. Write and read engines are independent and may run concurrently.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data bus width; legal values 32, 64, 128
MEM_DEPTH, 1024, memory depth in DATA_WIDTH words

Ports:
ACLK  in  1  clock, rising edge
ARESETn  in  1  synchronous active-low reset
AWADDR  in  ADDR_WIDTH  write burst start byte address
AWLEN  in  8  write beats minus 1
AWSIZE  in  3  bytes per beat = 2^AWSIZE
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte enables
WLAST  in  1  last write beat
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  00 OKAY, 10 SLVERR
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_WIDTH  read burst start byte address
ARLEN  in  8  read beats minus 1
ARSIZE  in  3  bytes per beat = 2^ARSIZE
ARBURST  in  2  burst type, as AWBURST
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  per-beat response
RLAST  out  1  last read beat
RVALID  out  1  read data valid
RREADY  in  1  read data ready

Behaviour:
- Reset: all outputs 0; both FSMs to IDLE. Reset mid-burst aborts the burst with no response. Memory contents are not cleared.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1. On AW handshake, latch addr/len/size/burst, clear beat count and error flag, go to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes bytes with WSTRB=1 to word addr>>log2(DATA_WIDTH/8), then advances the address.
  - On the beat where count==len, go to W_RESP, assert BVALID and drive BRESP.
  - W_RESP: hold BVALID and BRESP until BREADY, then W_IDLE. AWREADY is first reasserted the cycle after the B handshake.
- Address advance:
  - FIXED: address unchanged.
  - INCR: addr += 2^size (no 4KB check).
  - WRAP: addr += 2^size, wrapping within an aligned window of (len+1)*2^size bytes.
- Error causes, all giving SLVERR:
  - size > log2(DATA_WIDTH/8): whole burst suppressed (no writes).
  - WRAP with len not in {1,3,7,15}: burst treated as INCR.
  - Word index >= MEM_DEPTH: that beat is dropped.
  - WLAST not matching count==len on any beat.
  - The error flag is sticky for the burst, and BRESP reports it.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1. On AR handshake, latch fields and go to R_DATA.
  - RVALID rises in the cycle after the AR handshake. Throughput is 1 beat/cycle while RREADY=1.
  - RDATA, RRESP and RLAST stay stable while RVALID=1 and RREADY=0. RLAST=1 when count==len.
  - After the last handshake, RVALID=0 and the FSM returns to R_IDLE.
  - Out-of-range or illegal-size beat: RDATA=0, RRESP=SLVERR on that beat.
- Same-word read and write in the same cycle: the read returns the pre-write data.
- Narrow transfers: byte lanes are not masked by size; WSTRB alone selects the lanes written. RDATA returns the full word.

Optional Feature:
- Macro: AXI4_WRAP_BURST_EN.
- Defined: WRAP bursts are supported as described above.
- Undefined: AxBURST=10 is treated as INCR and the burst returns SLVERR (every R beat, and BRESP).
- AxBURST=11 (reserved) is always INCR plus SLVERR.

Test Plan:
- INCR write, AWADDR=0x0, AWLEN=3, AWSIZE=2, WSTRB=0xF, data 0x11..0x44 -> BRESP=00. Matching INCR read returns 0x11,0x22,0x33,0x44 with RLAST only on beat 4.
- WRAP write (DATA_WIDTH=32), AWADDR=0x8, AWLEN=3, AWSIZE=2 -> words 2,3,0,1 written in that order. Read back with INCR from 0x0 confirms, with BRESP=00.
- Partial write WSTRB=0x3, WDATA=0xAABBCCDD over a word holding 0x12345678 -> read returns 0x1234CCDD.
- Out-of-range: INCR write at word MEM_DEPTH-2, AWLEN=3 -> first 2 beats stored, BRESP=10. Read of the same range gives RRESP 00,00,10,10 and RDATA=0 on beats 3-4.
- Backpressure: 8-beat read with RREADY toggling every cycle -> RDATA stable while stalled, exactly 8 beats delivered. A BREADY stall of 5 cycles holds BVALID and keeps AWREADY=0.
- Reset mid-burst: ARESETn=0 after 2 of 4 write beats -> next cycle all outputs 0. The next write burst completes with OKAY, and the earlier 2 beats remain in memory.
